// File: rtl/pipelined_carry_select_subtractor_if.sv
// Streaming operand/result bundle for the pipelined carry-select subtractor.
// The master drives operands and accepts results; the slave is the subtractor.
interface pipelined_carry_select_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             borrow;
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, borrow, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, borrow, overflow
  );
endinterface

// File: rtl/pipelined_carry_select_subtractor.sv
// Two-stage carry-select subtractor, d = a - b (mod 2^WIDTH).
// Stage 1 computes the low-half difference and both speculative high halves;
// stage 2 picks the high half with the registered low carry.
// Valid/ready on both sides gives full throughput with backpressure.
module pipelined_carry_select_subtractor #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  pipelined_carry_select_subtractor_if.slave bus
);
  localparam int H = WIDTH / 2;

  // Handshake control
  logic s1_take;
  logic s2_take;

  // Stage-1 registers
  logic         s1_valid_reg;
  logic [H-1:0] d_lo_reg;
  logic         c_lo_reg;
  logic [H-1:0] h0_reg;
  logic         c0_reg;
  logic [H-1:0] h1_reg;
  logic         c1_reg;
  logic         a_msb_reg;
  logic         b_msb_reg;

  // Output-stage registers
  logic             out_valid_reg;
  logic [WIDTH-1:0] d_reg;
  logic             borrow_reg;
  logic             overflow_reg;

  // Stage-1 arithmetic: a + ~b + 1, low half plus two speculative high halves
  logic [H:0] lo_sum;
  logic [H:0] hi_sum [2];

  assign lo_sum = {1'b0, bus.a[H-1:0]} + {1'b0, ~bus.b[H-1:0]} + {{H{1'b0}}, 1'b1};

  // One high-half adder per assumed carry-in (gi = 0 / 1)
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_spec
      assign hi_sum[gi] = {1'b0, bus.a[WIDTH-1:H]} + {1'b0, ~bus.b[WIDTH-1:H]}
                        + {{H{1'b0}}, 1'(gi)};
    end
  endgenerate

  // Stage-2 select and flag generation
  logic [H:0]       hi_sel;
  logic [WIDTH-1:0] d_next;
  logic             cout_next;
  logic             overflow_next;

  assign hi_sel        = c_lo_reg ? {c1_reg, h1_reg} : {c0_reg, h0_reg};
  assign d_next        = {hi_sel[H-1:0], d_lo_reg};
  assign cout_next     = hi_sel[H];
  assign overflow_next = (a_msb_reg ^ b_msb_reg) & (d_next[WIDTH-1] ^ a_msb_reg);

  // in_ready depends only on registered valids and out_ready, never on in_valid
  assign s2_take = ~out_valid_reg | bus.out_ready;
  assign s1_take = ~s1_valid_reg | s2_take;

  assign bus.in_ready  = s1_take;
  assign bus.out_valid = out_valid_reg;
  assign bus.d         = d_reg;
  assign bus.borrow    = borrow_reg;
  assign bus.overflow  = overflow_reg;

  // Stage 1: capture low difference, speculative high halves and operand signs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      d_lo_reg     <= '0;
      c_lo_reg     <= 1'b0;
      h0_reg       <= '0;
      c0_reg       <= 1'b0;
      h1_reg       <= '0;
      c1_reg       <= 1'b0;
      a_msb_reg    <= 1'b0;
      b_msb_reg    <= 1'b0;
    end else if (s1_take) begin
      s1_valid_reg <= bus.in_valid;
      d_lo_reg     <= lo_sum[H-1:0];
      c_lo_reg     <= lo_sum[H];
      h0_reg       <= hi_sum[0][H-1:0];
      c0_reg       <= hi_sum[0][H];
      h1_reg       <= hi_sum[1][H-1:0];
      c1_reg       <= hi_sum[1][H];
      a_msb_reg    <= bus.a[WIDTH-1];
      b_msb_reg    <= bus.b[WIDTH-1];
    end
  end

  // Stage 2: register the selected result; holds while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      d_reg         <= '0;
      borrow_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (s2_take) begin
      out_valid_reg <= s1_valid_reg;
      d_reg         <= d_next;
      borrow_reg    <= ~cout_next;
      overflow_reg  <= overflow_next;
    end
  end
endmodule

// File: tb/tb_pipelined_carry_select_subtractor.sv
// Scoreboard bench for pipelined_carry_select_subtractor (WIDTH = 8).
// Inputs change 1 time unit after posedge; everything is sampled at negedge.
module tb_pipelined_carry_select_subtractor;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic check_latency = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       borrow;
    logic       overflow;
    int         cyc;
  } exp_t;

  exp_t sb [$];
  exp_t e;

  pipelined_carry_select_subtractor_if #(.WIDTH(8)) bus ();

  pipelined_carry_select_subtractor #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent reference: plain wide subtraction and signed range test
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input int c);
    exp_t r;
    int   sd;
    logic [8:0] diff;
    diff = {1'b0, x} - {1'b0, y};
    sd   = int'($signed(x)) - int'($signed(y));
    r.d        = diff[7:0];
    r.borrow   = (x < y);
    r.overflow = (sd > 127) || (sd < -128);
    r.cyc      = c;
    return r;
  endfunction

  // Monitor: pop/compare on output transfers, push on input transfers
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(bus.d), 32'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("d", 32'(bus.d), 32'(e.d));
          chk("borrow", 32'(bus.borrow), 32'(e.borrow));
          chk("overflow", 32'(bus.overflow), 32'(e.overflow));
          if (check_latency) chk("latency", 32'(cyc - e.cyc), 32'd2);
          $display("out d=%02h borrow=%0b ovf=%0b", bus.d, bus.borrow, bus.overflow);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.a, bus.b, cyc));
        $display("in  a=%02h b=%02h", bus.a, bus.b);
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = y;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [7:0] dir_a [5];
  logic [7:0] dir_b [5];
  logic [7:0] bp_a  [5];
  logic [7:0] bp_b  [5];
  logic [7:0] held;
  int         idx;

  initial begin
    dir_a = '{8'h50, 8'h10, 8'h00, 8'h80, 8'h7F};
    dir_b = '{8'h30, 8'h01, 8'h01, 8'h01, 8'hFF};
    bp_a  = '{8'hA5, 8'h3C, 8'h01, 8'hFE, 8'h77};
    bp_b  = '{8'h5A, 8'hC3, 8'h02, 8'h0F, 8'h88};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_d", 32'(bus.d), 32'd0);
    chk("rst_borrow", 32'(bus.borrow), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed single operations, 2-cycle latency checked
    check_latency = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(dir_a[i], dir_b[i]);
      bus.in_valid = 1'b0;
      drain();
      @(posedge clk);
      #1;
    end

    // Back-to-back random stream: latency 2 on every item means one per cycle
    for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: out_ready low for 5 cycles with in_valid high
    check_latency = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    idx  = 0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.a = bp_a[idx];
      bus.b = bp_b[idx];
      @(negedge clk);
      if (i >= 2) begin
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        if (i == 2) held = bus.d;
        else chk("bp_d_hold", 32'(bus.d), 32'(held));
      end
      if (bus.in_ready) idx++;
    end
    chk("bp_accepts", 32'(idx), 32'd2);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    chk("bp_no_dup", 32'(sb.size()), 32'd0);

    // Reset with both stages full: results must vanish
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(8'h12, 8'h34);
    send(8'h56, 8'h78);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_d", 32'(bus.d), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_discard", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
